// File: rtl/tx_engine_pkg.sv
// TLP codes, engine state encoding and header-DW builders for the 64-bit TX engine.
// Latency: n/a (package). Backpressure: n/a (package).
// Shared with the receive engine for fmt/type and completion status codes.
package tx_engine_pkg;

    // TLP {fmt, type} codes
    localparam logic [6:0] FMT_TYPE_CPLD   = 7'h4A;
    localparam logic [6:0] FMT_TYPE_MEM_RD = 7'h00;
    localparam logic [6:0] FMT_TYPE_MEM_WR = 7'h40;

    // Completion status: the engine only ever reports successful completion
    localparam logic [2:0] CPL_STATUS_SC = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CPL_HDR,
        ST_CPL_DAT,
        ST_CPL_WAIT,
        ST_MRD_HDR,
        ST_MRD_ADR
    } tx_state_e;

    // Fields captured from a decoded read request, held for the whole CplD
    typedef struct packed {
        logic [2:0]  tc;
        logic        td;
        logic        ep;
        logic [1:0]  attr;
        logic [9:0]  len;
        logic [15:0] rid;
        logic [7:0]  tag;
        logic [6:0]  addr;
        logic [31:0] data;
    } cpl_req_t;

    // Fields captured from a DMA read request, held for the whole MRd
    typedef struct packed {
        logic [31:0] addr;
        logic [9:0]  len;
    } mrd_req_t;

    function automatic logic [31:0] cpl_dw0(input logic [2:0] tc, input logic td,
                                            input logic ep, input logic [1:0] attr,
                                            input logic [9:0] len);
        return {1'b0, FMT_TYPE_CPLD, 1'b0, tc, 4'b0000, td, ep, attr, 2'b00, len};
    endfunction

    // Byte count is len*4: single-DW completions return whole DWs
    function automatic logic [31:0] cpl_dw1(input logic [15:0] cid, input logic [9:0] len);
        return {cid, CPL_STATUS_SC, 1'b0, len, 2'b00};
    endfunction

    function automatic logic [31:0] cpl_dw2(input logic [15:0] rid, input logic [7:0] tag,
                                            input logic [6:0] addr);
        return {rid, tag, 1'b0, addr & 7'h7C};
    endfunction

    function automatic logic [31:0] mrd_dw0(input logic [9:0] len);
        return {1'b0, FMT_TYPE_MEM_RD, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, len};
    endfunction

    // A single-DW read must carry last_BE of zero
    function automatic logic [31:0] mrd_dw1(input logic [15:0] cid, input logic [7:0] tag,
                                            input logic [9:0] len);
        return {cid, tag, (len == 10'd1) ? 4'h0 : 4'hF, 4'hF};
    endfunction

    function automatic logic [31:0] mrd_dw2(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/tx_engine.sv
// PCIe TX engine: sends 1-DW CplD (priority) and 32-bit MRd TLPs as two 64-bit beats.
// Latency: first beat valid one cycle after the request is sampled; done/ack one cycle after last beat.
// Backpressure: a beat is held frozen with tvalid high until tready; the FSM only advances on handshake.
//
// Ports: clk_i/rst_i (async active-high); s_axis_tx_* AXI-S TX beat out;
// completer_id_i + req_* + tx_reg_data_i / req_compl_wd_i / compl_done_o for completions;
// rd_req_i / rd_addr_i / rd_len_i / rd_ack_o / rd_tag_o for DMA memory reads.
module tx_engine
    import tx_engine_pkg::*;
#(
    parameter int C_DATA_WIDTH = 64
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    output logic [C_DATA_WIDTH-1:0]     s_axis_tx_tdata,
    output logic [C_DATA_WIDTH/8-1:0]   s_axis_tx_tkeep,
    output logic                        s_axis_tx_tlast,
    output logic                        s_axis_tx_tvalid,
    input  logic                        s_axis_tx_tready,
    input  logic [15:0]                 completer_id_i,
    input  logic                        req_compl_wd_i,
    input  logic [2:0]                  req_tc_i,
    input  logic                        req_td_i,
    input  logic                        req_ep_i,
    input  logic [1:0]                  req_attr_i,
    input  logic [9:0]                  req_len_i,
    input  logic [15:0]                 req_rid_i,
    input  logic [7:0]                  req_tag_i,
    input  logic [6:0]                  req_addr_i,
    input  logic [31:0]                 tx_reg_data_i,
    output logic                        compl_done_o,
    input  logic                        rd_req_i,
    input  logic [31:0]                 rd_addr_i,
    input  logic [9:0]                  rd_len_i,
    output logic                        rd_ack_o,
    output logic [7:0]                  rd_tag_o
);

    tx_state_e                   state_q, state_d;
    cpl_req_t                    cpl_q, cpl_d;
    mrd_req_t                    mrd_q, mrd_d;
    logic [15:0]                 cid_q, cid_d;
    logic [7:0]                  tag_cnt_q, tag_cnt_d;
    logic                        holdoff_q, holdoff_d;
    logic                        compl_done_q, compl_done_d;
    logic                        rd_ack_q, rd_ack_d;
    logic [7:0]                  rd_tag_q, rd_tag_d;
    logic [C_DATA_WIDTH-1:0]     tdata_q, tdata_d;
    logic [C_DATA_WIDTH/8-1:0]   tkeep_q, tkeep_d;
    logic                        tlast_q, tlast_d;
    logic                        tvalid_q, tvalid_d;

    always_comb begin
        state_d      = state_q;
        cpl_d        = cpl_q;
        mrd_d        = mrd_q;
        cid_d        = cid_q;
        tag_cnt_d    = tag_cnt_q;
        holdoff_d    = holdoff_q;
        compl_done_d = 1'b0;
        rd_ack_d     = 1'b0;
        rd_tag_d     = rd_tag_q;

        case (state_q)
            ST_IDLE: begin
                // Holdoff covers only the cycle rd_ack_o is visible, so a
                // requester that has not yet dropped rd_req_i is not re-served.
                holdoff_d = 1'b0;
                if (req_compl_wd_i) begin
                    cpl_d.tc   = req_tc_i;
                    cpl_d.td   = req_td_i;
                    cpl_d.ep   = req_ep_i;
                    cpl_d.attr = req_attr_i;
                    cpl_d.len  = req_len_i;
                    cpl_d.rid  = req_rid_i;
                    cpl_d.tag  = req_tag_i;
                    cpl_d.addr = req_addr_i;
                    cpl_d.data = tx_reg_data_i;
                    cid_d      = completer_id_i;
                    state_d    = ST_CPL_HDR;
                end else if (rd_req_i && !holdoff_q) begin
                    mrd_d.addr = rd_addr_i;
                    mrd_d.len  = rd_len_i;
                    cid_d      = completer_id_i;
                    state_d    = ST_MRD_HDR;
                end
            end
            ST_CPL_HDR: if (s_axis_tx_tready) state_d = ST_CPL_DAT;
            ST_CPL_DAT: begin
                if (s_axis_tx_tready) begin
                    compl_done_d = 1'b1;
                    state_d      = ST_CPL_WAIT;
                end
            end
            // The request is a level; wait for it to drop so it is not answered twice
            ST_CPL_WAIT: if (!req_compl_wd_i) state_d = ST_IDLE;
            ST_MRD_HDR: if (s_axis_tx_tready) state_d = ST_MRD_ADR;
            ST_MRD_ADR: begin
                if (s_axis_tx_tready) begin
                    rd_ack_d  = 1'b1;
                    rd_tag_d  = tag_cnt_q;
                    tag_cnt_d = tag_cnt_q + 8'd1;
                    holdoff_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Beat for the state being entered, built from the fields being latched.
        // During a stall state and fields are unchanged, so the beat is too.
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        tkeep_d  = '0;
        tdata_d  = '0;
        case (state_d)
            ST_CPL_HDR: begin
                tvalid_d = 1'b1;
                tkeep_d  = 8'hFF;
                tdata_d  = {cpl_dw1(cid_d, cpl_d.len),
                            cpl_dw0(cpl_d.tc, cpl_d.td, cpl_d.ep, cpl_d.attr, cpl_d.len)};
            end
            ST_CPL_DAT: begin
                tvalid_d = 1'b1;
                tlast_d  = 1'b1;
                tkeep_d  = 8'hFF;
                tdata_d  = {cpl_d.data, cpl_dw2(cpl_d.rid, cpl_d.tag, cpl_d.addr)};
            end
            ST_MRD_HDR: begin
                tvalid_d = 1'b1;
                tkeep_d  = 8'hFF;
                tdata_d  = {mrd_dw1(cid_d, tag_cnt_d, mrd_d.len), mrd_dw0(mrd_d.len)};
            end
            ST_MRD_ADR: begin
                tvalid_d = 1'b1;
                tlast_d  = 1'b1;
                tkeep_d  = 8'h0F;
                tdata_d  = {32'h0000_0000, mrd_dw2(mrd_d.addr)};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            cpl_q        <= '0;
            mrd_q        <= '0;
            cid_q        <= '0;
            tag_cnt_q    <= '0;
            holdoff_q    <= 1'b0;
            compl_done_q <= 1'b0;
            rd_ack_q     <= 1'b0;
            rd_tag_q     <= '0;
            tdata_q      <= '0;
            tkeep_q      <= '0;
            tlast_q      <= 1'b0;
            tvalid_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cpl_q        <= cpl_d;
            mrd_q        <= mrd_d;
            cid_q        <= cid_d;
            tag_cnt_q    <= tag_cnt_d;
            holdoff_q    <= holdoff_d;
            compl_done_q <= compl_done_d;
            rd_ack_q     <= rd_ack_d;
            rd_tag_q     <= rd_tag_d;
            tdata_q      <= tdata_d;
            tkeep_q      <= tkeep_d;
            tlast_q      <= tlast_d;
            tvalid_q     <= tvalid_d;
        end
    end

    assign s_axis_tx_tdata  = tdata_q;
    assign s_axis_tx_tkeep  = tkeep_q;
    assign s_axis_tx_tlast  = tlast_q;
    assign s_axis_tx_tvalid = tvalid_q;
    assign compl_done_o     = compl_done_q;
    assign rd_ack_o         = rd_ack_q;
    assign rd_tag_o         = rd_tag_q;

endmodule

// File: tb/tb_tx_engine.sv
// Self-checking bench for tx_engine: directed and randomized CplD/MRd traffic against a
// reference model built from the TLP field layout, with backpressure and reset cases.
// Checks beats, keep/last, stall stability, done/ack timing and tag sequence.
module tb_tx_engine;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [63:0] s_axis_tx_tdata;
    logic [7:0]  s_axis_tx_tkeep;
    logic        s_axis_tx_tlast;
    logic        s_axis_tx_tvalid;
    logic        s_axis_tx_tready;
    logic [15:0] completer_id_i;
    logic        req_compl_wd_i;
    logic [2:0]  req_tc_i;
    logic        req_td_i;
    logic        req_ep_i;
    logic [1:0]  req_attr_i;
    logic [9:0]  req_len_i;
    logic [15:0] req_rid_i;
    logic [7:0]  req_tag_i;
    logic [6:0]  req_addr_i;
    logic [31:0] tx_reg_data_i;
    logic        compl_done_o;
    logic        rd_req_i;
    logic [31:0] rd_addr_i;
    logic [9:0]  rd_len_i;
    logic        rd_ack_o;
    logic [7:0]  rd_tag_o;

    always #5 clk_i = ~clk_i;

    tx_engine #(.C_DATA_WIDTH(64)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .s_axis_tx_tdata(s_axis_tx_tdata), .s_axis_tx_tkeep(s_axis_tx_tkeep),
        .s_axis_tx_tlast(s_axis_tx_tlast), .s_axis_tx_tvalid(s_axis_tx_tvalid),
        .s_axis_tx_tready(s_axis_tx_tready),
        .completer_id_i(completer_id_i), .req_compl_wd_i(req_compl_wd_i),
        .req_tc_i(req_tc_i), .req_td_i(req_td_i), .req_ep_i(req_ep_i),
        .req_attr_i(req_attr_i), .req_len_i(req_len_i), .req_rid_i(req_rid_i),
        .req_tag_i(req_tag_i), .req_addr_i(req_addr_i), .tx_reg_data_i(tx_reg_data_i),
        .compl_done_o(compl_done_o),
        .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_len_i(rd_len_i),
        .rd_ack_o(rd_ack_o), .rd_tag_o(rd_tag_o)
    );

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int hs_cyc  = 0;
    logic [7:0] exp_tag = 8'd0;

    logic [63:0] cap_dat[$];
    logic [7:0]  cap_keep[$];
    logic        cap_last[$];
    int          done_cyc[$];
    int          ack_cyc[$];
    logic [7:0]  ack_tag[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (TLP field layout) ----------------
    function automatic logic [63:0] m_cpl_b0(input logic [15:0] cid, input logic [2:0] tc,
                                             input logic td, input logic ep,
                                             input logic [1:0] attr, input logic [9:0] len);
        logic [31:0] dw0, dw1;
        dw0 = 32'h4A00_0000 + (32'(tc) << 20) + (32'(td) << 15) + (32'(ep) << 14)
            + (32'(attr) << 12) + 32'(len);
        dw1 = (32'(cid) << 16) + 32'(len) * 32'd4;
        return {dw1, dw0};
    endfunction

    function automatic logic [63:0] m_cpl_b1(input logic [15:0] rid, input logic [7:0] tag,
                                             input logic [6:0] addr, input logic [31:0] data);
        logic [31:0] dw2;
        dw2 = (32'(rid) << 16) + (32'(tag) << 8) + (32'(addr) / 32'd4) * 32'd4;
        return {data, dw2};
    endfunction

    function automatic logic [63:0] m_mrd_b0(input logic [15:0] cid, input logic [7:0] tag,
                                             input logic [9:0] len);
        logic [31:0] dw0, dw1;
        dw0 = 32'(len);
        dw1 = (32'(cid) << 16) + (32'(tag) << 8) + ((len == 10'd1) ? 32'd0 : 32'd240) + 32'd15;
        return {dw1, dw0};
    endfunction

    function automatic logic [63:0] m_mrd_b1(input logic [31:0] addr);
        return {32'h0, (addr / 32'd4) * 32'd4};
    endfunction

    // bp_mode 0: always ready; 1: random; 2: beat0 stalled 5 cycles, beat1 stalled 3
    function automatic logic pick_ready(input int bp_mode, input int vcount);
        if (bp_mode == 0) return 1'b1;
        if (bp_mode == 1) return ($urandom_range(0, 3) != 0);
        return !((vcount <= 4) || (vcount >= 6 && vcount <= 8));
    endfunction

    task automatic clear_caps();
        cap_dat.delete(); cap_keep.delete(); cap_last.delete();
        done_cyc.delete(); ack_cyc.delete(); ack_tag.delete();
    endtask

    // One clock: log a handshake, advance, log pulses and verify any stalled beat held still
    task automatic tick();
        logic stalled;
        logic [63:0] pd;
        logic [7:0]  pk;
        logic        pl;
        stalled = (s_axis_tx_tvalid === 1'b1) && (s_axis_tx_tready === 1'b0);
        pd = s_axis_tx_tdata; pk = s_axis_tx_tkeep; pl = s_axis_tx_tlast;
        if (s_axis_tx_tvalid && s_axis_tx_tready) begin
            cap_dat.push_back(s_axis_tx_tdata);
            cap_keep.push_back(s_axis_tx_tkeep);
            cap_last.push_back(s_axis_tx_tlast);
            hs_cyc = cyc;
        end
        @(posedge clk_i);
        #1;
        cyc++;
        if (compl_done_o) done_cyc.push_back(cyc);
        if (rd_ack_o) begin
            ack_cyc.push_back(cyc);
            ack_tag.push_back(rd_tag_o);
        end
        if (stalled && !rst_i) begin
            check("stall_vld",  64'(s_axis_tx_tvalid), 64'd1);
            check("stall_dat",  s_axis_tx_tdata, pd);
            check("stall_keep", 64'(s_axis_tx_tkeep), 64'(pk));
            check("stall_last", 64'(s_axis_tx_tlast), 64'(pl));
        end
    endtask

    task automatic run_cpl(input int bp_mode, input int hold_extra);
        logic [63:0] e0, e1;
        int vcount, first_v, start;
        e0 = m_cpl_b0(completer_id_i, req_tc_i, req_td_i, req_ep_i, req_attr_i, req_len_i);
        e1 = m_cpl_b1(req_rid_i, req_tag_i, req_addr_i, tx_reg_data_i);
        clear_caps();
        req_compl_wd_i = 1'b1;
        start = cyc; vcount = 0; first_v = -1;
        for (int i = 0; i < 200 && done_cyc.size() == 0; i++) begin
            s_axis_tx_tready = pick_ready(bp_mode, vcount);
            if (s_axis_tx_tvalid) vcount++;
            tick();
            if (first_v < 0 && s_axis_tx_tvalid) first_v = cyc;
        end
        s_axis_tx_tready = 1'b1;
        for (int k = 0; k < hold_extra; k++) tick();
        check("cpl_latency", 64'(first_v), 64'(start + 1));
        check("cpl_done_cnt", 64'(done_cyc.size()), 64'd1);
        check("cpl_beats", 64'(cap_dat.size()), 64'd2);
        if (cap_dat.size() >= 2 && done_cyc.size() >= 1) begin
            check("cpl_b0_dat",  cap_dat[0], e0);
            check("cpl_b0_keep", 64'(cap_keep[0]), 64'hFF);
            check("cpl_b0_last", 64'(cap_last[0]), 64'd0);
            check("cpl_b1_dat",  cap_dat[1], e1);
            check("cpl_b1_keep", 64'(cap_keep[1]), 64'hFF);
            check("cpl_b1_last", 64'(cap_last[1]), 64'd1);
            check("cpl_done_time", 64'(done_cyc[0]), 64'(hs_cyc + 1));
        end
        req_compl_wd_i = 1'b0;
        tick();
    endtask

    task automatic run_mrd(input int bp_mode);
        logic [63:0] e0, e1;
        int vcount, first_v, start;
        e0 = m_mrd_b0(completer_id_i, exp_tag, rd_len_i);
        e1 = m_mrd_b1(rd_addr_i);
        clear_caps();
        rd_req_i = 1'b1;
        start = cyc; vcount = 0; first_v = -1;
        for (int i = 0; i < 200 && ack_cyc.size() == 0; i++) begin
            s_axis_tx_tready = pick_ready(bp_mode, vcount);
            if (s_axis_tx_tvalid) vcount++;
            tick();
            if (first_v < 0 && s_axis_tx_tvalid) first_v = cyc;
        end
        rd_req_i = 1'b0;
        s_axis_tx_tready = 1'b1;
        check("mrd_latency", 64'(first_v), 64'(start + 1));
        check("mrd_ack_cnt", 64'(ack_cyc.size()), 64'd1);
        check("mrd_beats", 64'(cap_dat.size()), 64'd2);
        if (cap_dat.size() >= 2 && ack_cyc.size() >= 1) begin
            check("mrd_b0_dat",  cap_dat[0], e0);
            check("mrd_b0_keep", 64'(cap_keep[0]), 64'hFF);
            check("mrd_b0_last", 64'(cap_last[0]), 64'd0);
            check("mrd_b1_dat",  cap_dat[1], e1);
            check("mrd_b1_keep", 64'(cap_keep[1]), 64'h0F);
            check("mrd_b1_last", 64'(cap_last[1]), 64'd1);
            check("mrd_tag", 64'(ack_tag[0]), 64'(exp_tag));
            check("mrd_ack_time", 64'(ack_cyc[0]), 64'(hs_cyc + 1));
        end
        exp_tag = exp_tag + 8'd1;
        tick();
    endtask

    task automatic rand_cpl_fields();
        completer_id_i = 16'($urandom);
        req_tc_i = 3'($urandom);  req_td_i = 1'($urandom);  req_ep_i = 1'($urandom);
        req_attr_i = 2'($urandom); req_len_i = 10'($urandom); req_rid_i = 16'($urandom);
        req_tag_i = 8'($urandom);  req_addr_i = 7'($urandom); tx_reg_data_i = $urandom;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_tvalid"}, 64'(s_axis_tx_tvalid), 64'd0);
        check({pfx, "_tlast"},  64'(s_axis_tx_tlast), 64'd0);
        check({pfx, "_tdata"},  s_axis_tx_tdata, 64'd0);
        check({pfx, "_tkeep"},  64'(s_axis_tx_tkeep), 64'd0);
        check({pfx, "_done"},   64'(compl_done_o), 64'd0);
        check({pfx, "_ack"},    64'(rd_ack_o), 64'd0);
        check({pfx, "_rd_tag"}, 64'(rd_tag_o), 64'd0);
    endtask

    initial begin
        logic [63:0] c0, c1, m0, m1;
        int vc;
        rst_i = 1'b1;
        s_axis_tx_tready = 1'b1;
        req_compl_wd_i = 1'b0; rd_req_i = 1'b0;
        completer_id_i = 16'h0100; req_tc_i = 3'd0; req_td_i = 1'b0; req_ep_i = 1'b0;
        req_attr_i = 2'd0; req_len_i = 10'd1; req_rid_i = 16'h0000; req_tag_i = 8'h05;
        req_addr_i = 7'h14; tx_reg_data_i = 32'hDEADBEEF;
        rd_addr_i = 32'h1000_0040; rd_len_i = 10'd32;

        // Reset state
        tick(); tick();
        check_reset_outputs("rst");
        rst_i = 1'b0;
        tick();

        // Directed CplD, then hold the request 3 more cycles: no resend
        if (m_cpl_b0(16'h0100, 3'd0, 1'b0, 1'b0, 2'd0, 10'd1) != 64'h01000004_4A000001 ||
            m_cpl_b1(16'h0000, 8'h05, 7'h14, 32'hDEADBEEF) != 64'hDEADBEEF_00000514)
            $display("note: model disagrees with documented CplD example");
        run_cpl(0, 3);

        // Directed MRd: tag 0 then tag 1
        run_mrd(0);
        run_mrd(0);

        // MRd with len=1: last_BE zero
        rd_addr_i = 32'h0000_1234; rd_len_i = 10'd1;
        run_mrd(0);
        check("len1_be_byte", 64'(cap_dat.size() >= 1 ? cap_dat[0][39:32] : 8'hEE), 64'h0F);

        // Backpressure: beat0 stalled 5 cycles, beat1 stalled 3
        completer_id_i = 16'h0100; req_len_i = 10'd1;
        run_cpl(2, 0);
        rd_addr_i = 32'h1000_0040; rd_len_i = 10'd32;
        run_mrd(2);

        // Simultaneous requests: CplD first, then MRd
        rand_cpl_fields();
        rd_addr_i = $urandom; rd_len_i = 10'($urandom);
        c0 = m_cpl_b0(completer_id_i, req_tc_i, req_td_i, req_ep_i, req_attr_i, req_len_i);
        c1 = m_cpl_b1(req_rid_i, req_tag_i, req_addr_i, tx_reg_data_i);
        m0 = m_mrd_b0(completer_id_i, exp_tag, rd_len_i);
        m1 = m_mrd_b1(rd_addr_i);
        clear_caps();
        req_compl_wd_i = 1'b1; rd_req_i = 1'b1; s_axis_tx_tready = 1'b1;
        for (int i = 0; i < 100 && ack_cyc.size() == 0; i++) begin
            tick();
            if (done_cyc.size() != 0) req_compl_wd_i = 1'b0;
        end
        rd_req_i = 1'b0;
        req_compl_wd_i = 1'b0;
        check("sim_beats", 64'(cap_dat.size()), 64'd4);
        check("sim_acks", 64'(ack_cyc.size() + done_cyc.size()), 64'd2);
        if (cap_dat.size() >= 4 && ack_cyc.size() >= 1 && done_cyc.size() >= 1) begin
            check("sim_cpl_b0", cap_dat[0], c0);
            check("sim_cpl_b1", cap_dat[1], c1);
            check("sim_mrd_b0", cap_dat[2], m0);
            check("sim_mrd_b1", cap_dat[3], m1);
            check("sim_order", 64'(ack_cyc[0] > done_cyc[0]), 64'd1);
            check("sim_tag", 64'(ack_tag[0]), 64'(exp_tag));
        end
        exp_tag = exp_tag + 8'd1;
        tick();

        // Randomized mix with random backpressure
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                rand_cpl_fields();
                run_cpl(1, 0);
            end else begin
                completer_id_i = 16'($urandom);
                rd_addr_i = $urandom; rd_len_i = 10'($urandom);
                run_mrd(1);
            end
        end

        // Walk the tag counter through its wrap: MRds until tag 255 has been used, then tag 0
        rd_addr_i = 32'h2000_0000; rd_len_i = 10'd8;
        while (exp_tag != 8'd0) run_mrd(0);
        check("wrap_last_tag", 64'(ack_tag.size() >= 1 ? ack_tag[0] : 8'h00), 64'hFF);
        run_mrd(0);
        check("wrap_tag0", 64'(ack_tag.size() >= 1 ? ack_tag[0] : 8'hEE), 64'h00);

        // Reset while beat1 is presented and stalled
        rand_cpl_fields();
        clear_caps();
        req_compl_wd_i = 1'b1;
        vc = 0;
        for (int i = 0; i < 20 && !(s_axis_tx_tvalid && s_axis_tx_tlast); i++) begin
            s_axis_tx_tready = (vc == 0) && s_axis_tx_tvalid;
            if (s_axis_tx_tvalid) vc++;
            tick();
        end
        check("rst_beat1_seen", 64'(s_axis_tx_tvalid && s_axis_tx_tlast), 64'd1);
        s_axis_tx_tready = 1'b0;
        rst_i = 1'b1;
        #1;
        check_reset_outputs("midrst");
        req_compl_wd_i = 1'b0;
        tick(); tick();
        rst_i = 1'b0;
        s_axis_tx_tready = 1'b1;
        exp_tag = 8'd0;
        tick();
        rand_cpl_fields();
        run_cpl(0, 0);
        rd_addr_i = 32'h0000_0100; rd_len_i = 10'd4;
        run_mrd(0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
